ctrl_capture_fsm: RTL
=====================

Name: ctrl_capture_fsm

Overview:
Top-level capture sequencer for the pixel-array camera. It takes the exposure setting produced by the exposure-time controller and a user start button, then drives the array control strobes in order: erase (hold), expose, and readout of two pixel rows through the shared ADC. It also freezes the exposure-time controller while a capture is in progress.

Parameters:
UNIT_CYCLES, 1, clock cycles per exposure-time unit (>=1)
ADC_CYCLES, 2, cycles adc is held high per row conversion (>=1)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
init  input  1  capture start button, level input
ex_time  input  5  exposure setting from exposure-time controller, units of UNIT_CYCLES
erase  output  1  pixel erase, high = pixels held erased
expose  output  1  pixel exposure enable
nre_1  output  1  row 1 read enable, active low
nre_2  output  1  row 2 read enable, active low
adc  output  1  ADC sample/convert strobe, shared by both rows
busy  output  1  high whenever state != IDLE
ex_lock  output  1  equals busy; inhibits exposure-time adjustment
frame_done  output  1  one-cycle pulse on return to IDLE after a completed readout

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs registered (Moore, decoded from state registers); no combinational input-to-output paths.
- Reset values: state=IDLE, erase=1, expose=0, nre_1=1, nre_2=1, adc=0, busy=0, ex_lock=0, frame_done=0, init_q=0, counters=0.
- Start detect: start = init & ~init_q, where init_q is init registered every cycle. Held-high init starts only one capture. Init held across reset release starts a capture once, at the first edge where init=1 and init_q=0.
- States: IDLE, EXPOSE, SEL1, CONV1, DESEL1, SEL2, CONV2, DESEL2.
- IDLE: erase=1, all other strobes inactive. On start, latch ex_lat = (ex_time==0 ? 1 : ex_time) and go to EXPOSE. If start is sampled at edge k, expose=1 in the cycle after edge k.
- EXPOSE: erase=0, expose=1 for exactly ex_lat*UNIT_CYCLES cycles, then SEL1. Counter width = $clog2(31*UNIT_CYCLES+1).
- SEL1: nre_1=0, 1 cycle. CONV1: nre_1=0, adc=1, ADC_CYCLES cycles. DESEL1: all strobes inactive, erase=0, 1 cycle.
- SEL2, CONV2, DESEL2: same as SEL1, CONV1, DESEL1 using nre_2. After DESEL2, go to IDLE.
- frame_done=1 for the first IDLE cycle after DESEL2 only. It is not asserted after reset or after an aborted capture.
- erase stays 0 from the first EXPOSE cycle through DESEL2. It returns to 1 in IDLE.
- Readout length = 2*(ADC_CYCLES+2) cycles. nre_1 and nre_2 are never low together. adc is high only while exactly one nre is low.
- busy and ex_lock are high in every non-IDLE state.
- Start while busy: ignored. Not queued.
- ex_time changes while busy: ignored, because ex_lat is held. The new value applies to the next capture.
- Reset mid-capture (any state): at the next edge, all outputs take their reset values and the capture is abandoned. Reset has priority over start in the same cycle.

Test Plan:
- Reset/idle: reset high 2 cycles, then low, init=0 -> erase=1, expose=0, nre_1=nre_2=1, adc=0, busy=0, frame_done=0, held for 10 cycles.
- Nominal capture, UNIT=1, ADC=2, ex_time=5, 1-cycle init pulse -> expose high 5 cycles. Then nre_1 low 3 cycles with adc high in cycles 2-3 of that window, 1 gap cycle, the same pattern on nre_2, 1 gap cycle. Then frame_done high 1 cycle with erase=1. busy high for exactly 13 cycles.
- Edge cases: ex_time=0 -> expose high 1 cycle. ex_time=31 -> expose high 31 cycles. UNIT=3, ex_time=4 -> expose high 12 cycles.
- Held init and busy: init held high 40 cycles with ex_time=2 -> exactly one capture, one frame_done. A second init pulse during CONV1 -> ignored. Changing ex_time from 5 to 9 mid-EXPOSE -> expose length stays 5 cycles; the next capture uses 9.
- Abort: reset asserted during EXPOSE, and separately during CONV2 -> next cycle shows reset values, no frame_done. A fresh init pulse then runs a normal capture.
- Protocol checks over 20 random ex_time captures: nre_1 and nre_2 never both low; adc never high while both nre are high; erase and expose never both high; ex_lock always equals busy.

Source files
------------

// File: rtl/ctrl_capture_fsm_if.sv
// Capture-sequencer bus: exposure setting and start button in, pixel-array strobes out.
// The slave modport is the sequencer; the master modport is whoever drives init/ex_time.
interface ctrl_capture_fsm_if;
    logic       init;
    logic [4:0] ex_time;
    logic       erase;
    logic       expose;
    logic       nre_1;
    logic       nre_2;
    logic       adc;
    logic       busy;
    logic       ex_lock;
    logic       frame_done;

    modport master (
        output init, ex_time,
        input  erase, expose, nre_1, nre_2, adc, busy, ex_lock, frame_done
    );

    modport slave (
        input  init, ex_time,
        output erase, expose, nre_1, nre_2, adc, busy, ex_lock, frame_done
    );
endinterface

// File: rtl/ctrl_capture_fsm.sv
// Capture sequencer: erase hold, timed exposure, then two-row readout through a shared ADC.
// All strobes are registered and decoded from the next state, so they line up with the state register.
module ctrl_capture_fsm #(
    parameter int unsigned UNIT_CYCLES = 1,
    parameter int unsigned ADC_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    ctrl_capture_fsm_if.slave  bus
);
    localparam int unsigned EXP_W = $clog2(31 * UNIT_CYCLES + 1);
    localparam int unsigned ADC_W = $clog2(ADC_CYCLES + 1);
    localparam int unsigned CNT_W = (EXP_W > ADC_W) ? EXP_W : ADC_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXPOSE = 3'd1,
        SEL1   = 3'd2,
        CONV1  = 3'd3,
        DESEL1 = 3'd4,
        SEL2   = 3'd5,
        CONV2  = 3'd6,
        DESEL2 = 3'd7
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic               init_q;
    logic               start_c;
    logic [4:0]         ex_eff_c;
    logic [CNT_W-1:0]   exp_len_c;

    logic erase_d;
    logic expose_d;
    logic nre_1_d;
    logic nre_2_d;
    logic adc_d;
    logic busy_d;
    logic frame_done_d;

    // Next state, dwell counter and strobe decode of the next state
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        start_c   = bus.init & ~init_q;
        ex_eff_c  = (bus.ex_time == 5'd0) ? 5'd1 : bus.ex_time;
        exp_len_c = CNT_W'(ex_eff_c) * CNT_W'(UNIT_CYCLES);

        // Exposure length is loaded into the counter at start, so later ex_time edits cannot touch it
        case (state)
            IDLE: begin
                if (start_c) begin
                    state_d = EXPOSE;
                    cnt_d   = exp_len_c - CNT_W'(1);
                end
            end
            EXPOSE: begin
                if (cnt == '0) state_d = SEL1;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            SEL1: begin
                state_d = CONV1;
                cnt_d   = CNT_W'(ADC_CYCLES - 1);
            end
            CONV1: begin
                if (cnt == '0) state_d = DESEL1;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            DESEL1: state_d = SEL2;
            SEL2: begin
                state_d = CONV2;
                cnt_d   = CNT_W'(ADC_CYCLES - 1);
            end
            CONV2: begin
                if (cnt == '0) state_d = DESEL2;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            DESEL2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        erase_d      = (state_d == IDLE);
        expose_d     = (state_d == EXPOSE);
        nre_1_d      = !((state_d == SEL1) || (state_d == CONV1));
        nre_2_d      = !((state_d == SEL2) || (state_d == CONV2));
        adc_d        = (state_d == CONV1) || (state_d == CONV2);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state == DESEL2);
    end

    // State, counter, start-edge history and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            init_q         <= 1'b0;
            bus.erase      <= 1'b1;
            bus.expose     <= 1'b0;
            bus.nre_1      <= 1'b1;
            bus.nre_2      <= 1'b1;
            bus.adc        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.ex_lock    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            init_q         <= bus.init;
            bus.erase      <= erase_d;
            bus.expose     <= expose_d;
            bus.nre_1      <= nre_1_d;
            bus.nre_2      <= nre_2_d;
            bus.adc        <= adc_d;
            bus.busy       <= busy_d;
            bus.ex_lock    <= busy_d;
            bus.frame_done <= frame_done_d;
        end
    end
endmodule
